fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V pipeline. It holds the PC, issues word fetches to instruction memory over a req/ack handshake, and delivers {pc, pc+4, instr} with a valid bit to the decode stage. In decode, if_id_instr feeds the immediate generator and the register file. It honours hazard-unit stalls and branch/jump redirects, and never loses or duplicates an instruction.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect inputs, instruction-memory
// handshake and the IF/ID pipeline register outputs. The master side is
// the fetch stage itself; the slave side is its environment.
interface fetch_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// FETCH issues word requests; HOLD parks a word fetched under stall in a
// skid register; DROP waits out an in-flight request after a redirect so
// the late data is discarded and the redirect target is fetched next.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_instr_r;
  logic        if_id_valid_r;
  logic [31:0] if_id_pc_r;
  logic [31:0] if_id_pc4_r;
  logic [31:0] if_id_instr_r;

  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign target_s   = word_align(bus.redirect_pc_i);
  assign pc_plus4_s = pc_r + 32'd4;

  // Request is decoded from state so a fetch goes out the same cycle the
  // FSM enters FETCH/DROP; it is forced low while reset is asserted.
  assign bus.imem_req    = rst_n && ((state_r == FETCH) || (state_r == DROP));
  assign bus.imem_addr   = pc_r;
  assign bus.if_id_valid = if_id_valid_r;
  assign bus.if_id_pc    = if_id_pc_r;
  assign bus.if_id_pc4   = if_id_pc4_r;
  assign bus.if_id_instr = if_id_instr_r;

  // Fetch FSM, PC, skid and IF/ID register; priority reset > redirect > ack/stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      pend_pc_r     <= 32'h0000_0000;
      skid_pc_r     <= 32'h0000_0000;
      skid_instr_r  <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_pc4_r   <= 32'h0000_0004;
      if_id_instr_r <= NOP_INSTR;
    end else begin
      case (state_r)
        FETCH: begin
          if (bus.redirect_i) begin
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= NOP_INSTR;
            skid_pc_r     <= 32'h0000_0000;
            skid_instr_r  <= 32'h0000_0000;
            if (bus.imem_ack) begin
              pc_r    <= target_s;
              state_r <= FETCH;
            end else begin
              // Outstanding request must still complete; park the target.
              pend_pc_r <= target_s;
              state_r   <= DROP;
            end
          end else if (bus.imem_ack) begin
            pc_r <= pc_plus4_s;
            if (bus.stall_i) begin
              skid_pc_r    <= pc_r;
              skid_instr_r <= bus.imem_rdata;
              state_r      <= HOLD;
            end else begin
              if_id_valid_r <= 1'b1;
              if_id_pc_r    <= pc_r;
              if_id_pc4_r   <= pc_plus4_s;
              if_id_instr_r <= bus.imem_rdata;
              state_r       <= FETCH;
            end
          end else if (!bus.stall_i) begin
            // Decode consumed its word and nothing new arrived: bubble.
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= NOP_INSTR;
          end else begin
            state_r <= FETCH;
          end
        end

        HOLD: begin
          if (bus.redirect_i) begin
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= NOP_INSTR;
            skid_pc_r     <= 32'h0000_0000;
            skid_instr_r  <= 32'h0000_0000;
            pc_r          <= target_s;
            state_r       <= FETCH;
          end else if (!bus.stall_i) begin
            if_id_valid_r <= 1'b1;
            if_id_pc_r    <= skid_pc_r;
            if_id_pc4_r   <= skid_pc_r + 32'd4;
            if_id_instr_r <= skid_instr_r;
            state_r       <= FETCH;
          end else begin
            state_r <= HOLD;
          end
        end

        DROP: begin
          if_id_valid_r <= 1'b0;
          if_id_instr_r <= NOP_INSTR;
          if (bus.redirect_i) begin
            if (bus.imem_ack) begin
              // In-flight request just completed: go straight to the newest target.
              pc_r    <= target_s;
              state_r <= FETCH;
            end else begin
              pend_pc_r <= target_s;
              state_r   <= DROP;
            end
          end else if (bus.imem_ack) begin
            pc_r    <= pend_pc_r;
            state_r <= FETCH;
          end else begin
            state_r <= DROP;
          end
        end

        default: begin
          if_id_valid_r <= 1'b0;
          if_id_instr_r <= NOP_INSTR;
          state_r       <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Each vector gives this
// cycle's inputs and the outputs expected to be visible in that same cycle.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] rpc,
                              logic a, logic [31:0] rd, logic q, logic [31:0] ad,
                              logic v, logic [31:0] p, logic [31:0] p4, logic [31:0] ins);
    vec_t t;
    t.rst_n = r;  t.stall = s;  t.redir = d;  t.rpc = rpc;  t.ack = a;  t.rdata = rd;
    t.e_req = q;  t.e_addr = ad; t.e_valid = v; t.e_pc = p; t.e_pc4 = p4; t.e_instr = ins;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle.
  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                       input logic a, input logic [31:0] rd);
    @(negedge clk);
    rst_n             = r;
    bus.stall_i       = s;
    bus.redirect_i    = d;
    bus.redirect_pc_i = rpc;
    bus.imem_ack      = a;
    bus.imem_rdata    = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;

    //            rst   stall redir rpc           ack   rdata          req   addr          val   pc            pc4           instr
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0013);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0050_0093, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0013);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00a0_0113, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'h00a0_0113);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004, 32'h0000_0008, 32'h0000_0013);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0010_8093, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004, 32'h0000_0008, 32'h0000_0013);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0020_8113, 1'b1, 32'h0000_000c, 1'b1, 32'h0000_0008, 32'h0000_000c, 32'h0010_8093);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_000c, 32'h0010_8093);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_000c, 32'h0010_8093);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_000c, 32'h0010_8093);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_000c, 32'h0000_0010, 32'h0020_8113);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 32'h0000_000c, 32'h0000_0010, 32'h0000_0013);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b0, 32'h0000_000c, 32'h0000_0010, 32'h0000_0013);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hdead_beef, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000c, 32'h0000_0010, 32'h0000_0013);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0000_000c, 32'h0000_0010, 32'h0000_0013);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0030_0193, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_000c, 32'h0000_0010, 32'h0000_0013);
    tbl[16] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0bad_f00d, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0000_0104, 32'h0030_0193);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0013);
    tbl[18] = mk(1'b1, 1'b0, 1'b1, 32'hffff_fffe, 1'b1, 32'h0bad_f00d, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0013);
    tbl[19] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0213, 1'b1, 32'hffff_fffc, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0013);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 32'hffff_fffc, 32'h0000_0000, 32'h0040_0213);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0013);

    // Hold reset for a couple of edges before the table starts.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].rdata);
      chk($sformatf("v%0d.req", i),   {31'd0, bus.imem_req},    {31'd0, tbl[i].e_req});
      chk($sformatf("v%0d.addr", i),  bus.imem_addr,            tbl[i].e_addr);
      chk($sformatf("v%0d.valid", i), {31'd0, bus.if_id_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d.pc", i),    bus.if_id_pc,             tbl[i].e_pc);
      chk($sformatf("v%0d.pc4", i),   bus.if_id_pc4,            tbl[i].e_pc4);
      chk($sformatf("v%0d.instr", i), bus.if_id_instr,          tbl[i].e_instr);
    end

    // Reset while a word sits in the skid: it must not leak out afterwards.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
    chk("hs.req0",  {31'd0, bus.imem_req}, 32'd1);
    chk("hs.addr0", bus.imem_addr, 32'h0000_0000);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0020_0093);
    chk("hs.instr1", bus.if_id_instr, 32'h0010_0093);
    chk("hs.addr1",  bus.imem_addr, 32'h0000_0004);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hs.holdreq", {31'd0, bus.imem_req}, 32'd0);
    chk("hs.holdaddr", bus.imem_addr, 32'h0000_0008);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hs.rstreq",   {31'd0, bus.imem_req}, 32'd1);
    chk("hs.rstaddr",  bus.imem_addr, 32'h0000_0000);
    chk("hs.rstvalid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("hs.rstinstr", bus.if_id_instr, 32'h0000_0013);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hs.noleak", {31'd0, bus.if_id_valid}, 32'd0);

    // Reset while in DROP: first fetch after reset goes to RESET_PC, not the parked target.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    chk("hd.req", {31'd0, bus.imem_req}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hd.rstreq", {31'd0, bus.imem_req}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0060_0313);
    chk("hd.addr", bus.imem_addr, 32'h0000_0000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hd.valid", {31'd0, bus.if_id_valid}, 32'd1);
    chk("hd.pc",    bus.if_id_pc, 32'h0000_0000);
    chk("hd.instr", bus.if_id_instr, 32'h0060_0313);
    chk("hd.next",  bus.imem_addr, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
